prefetch_unit: RTL and testbench
================================

PREFETCH_UNIT -- requirements
Module: prefetch_unit

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default simple_processor_pkg::ADDR_WIDTH, instruction address width.
REQ-002 SHALL have parameter DATA_WIDTH, default simple_processor_pkg::DATA_WIDTH, instruction word width.
REQ-003 SHALL have parameter DEPTH, default 4, prefetch buffer entries; a power of two and at least 2.
REQ-004 SHALL have parameter INSTR_BYTES, default simple_processor_pkg::INSTR_BYTES (=2), PC increment per instruction.
REQ-005 SHALL have ports:
- clk_i  in  1  sole clock.
- rst_i  in  1  synchronous, active-high reset.
- boot_addr_i  in  ADDR_WIDTH  first fetch address after reset.
- redirect_i  in  1  one-cycle flush/redirect pulse.
- redirect_addr_i  in  ADDR_WIDTH  new fetch address.
- imem_req_o  out  1  fetch request.
- imem_addr_o  out  ADDR_WIDTH  fetch address.
- imem_rdata_i  in  DATA_WIDTH  fetched word.
- imem_ack_i  in  1  fetch complete, data valid.
- instr_valid_o  out  1  buffer head valid.
- instr_o  out  DATA_WIDTH  head instruction.
- instr_pc_o  out  ADDR_WIDTH  head instruction address.
- instr_ready_i  in  1  consumer accepts head.

Function
REQ-006 SHALL keep at most one memory request outstanding; once imem_req_o rises, imem_req_o and imem_addr_o SHALL stay stable until the cycle imem_ack_i is high.
REQ-007 SHALL accept imem_ack_i in the same cycle imem_req_o first rises (zero-wait memory); imem_ack_i while imem_req_o is low SHALL be ignored.
REQ-008 SHALL have states BOOT, FETCH, DISCARD. BOOT is the first cycle after reset: fetch_pc <= boot_addr_i, then go to FETCH.
REQ-009 In FETCH, imem_req_o SHALL be high when the buffer count < DEPTH or a request is in progress. imem_addr_o SHALL equal fetch_pc.
REQ-010 On ack in FETCH with no redirect:
- {imem_rdata_i, fetch_pc} SHALL be pushed.
- fetch_pc SHALL advance by INSTR_BYTES, wrapping modulo 2^ADDR_WIDTH.
- The next request MAY start in the following cycle.
REQ-011 instr_valid_o SHALL equal (count != 0). instr_o and instr_pc_o SHALL show the head entry. A pop SHALL occur when instr_valid_o && instr_ready_i.
REQ-012 Simultaneous push and pop SHALL leave count unchanged. A push at count == DEPTH SHALL be impossible by construction. A pop at count 0 SHALL be ignored.
REQ-013 redirect_i SHALL have priority over push and pop. It SHALL:
- empty the buffer, so instr_valid_o is low the next cycle;
- set fetch_pc <= redirect_addr_i.
REQ-014 Redirect with a request in progress and no ack that cycle SHALL go to DISCARD. DISCARD SHALL hold the old request until ack, drop that data, then return to FETCH.
REQ-015 Redirect in the same cycle as an ack SHALL drop that data, stay in FETCH, and request redirect_addr_i the next cycle.
REQ-016 Redirect while in DISCARD SHALL overwrite fetch_pc and remain in DISCARD.
REQ-017 Redirect during BOOT SHALL win over boot_addr_i.
REQ-018 Latency: with zero-wait memory, the first instruction SHALL appear on instr_valid_o two cycles after rst_i falls, i.e. BOOT cycle + request/ack cycle.
REQ-019 Throughput: with zero-wait memory and instr_ready_i held high, one instruction SHALL be delivered per cycle.

Reset
REQ-020 While rst_i is high, all of the following SHALL hold on the next clk_i edge:
- imem_req_o=0, imem_addr_o='0, instr_valid_o=0, count=0.
- state=BOOT, and no request is outstanding.
REQ-021 Reset asserted mid-request SHALL abandon the request; an ack in the reset cycle SHALL be ignored.

Structure
REQ-022 simple_processor_pkg SHALL hold typedef fetch_state_e {BOOT, FETCH, DISCARD} and constant INSTR_BYTES.
REQ-023 The buffer SHALL be one sub-module, sync_fifo (parameters WIDTH, DEPTH; ports push, pop, flush, full, empty, count), clocked by clk_i and reset by rst_i.
REQ-024 The FSM, the fetch_pc register and the request logic SHALL live in prefetch_unit.

Verification
REQ-025 Reset release, boot_addr_i=0x0100, zero-wait memory, ready=1 -> addresses 0x0100, 0x0102, 0x0104 requested on consecutive cycles; first instr_valid_o two cycles after reset release.
REQ-026 ready=0, DEPTH=4 -> exactly 4 acks accepted, then imem_req_o=0. Ready=1 for one cycle -> one pop, then one new request at head_pc+8.
REQ-027 Memory ack delay 3 cycles, redirect_i (0x0400) on the cycle after req rises -> req/addr held until ack, data dropped, next request to 0x0400, no stale instr_valid_o.
REQ-028 Redirect coincident with ack and a full buffer -> buffer empty the next cycle, request 0x0400 the following cycle.
REQ-029 ADDR_WIDTH=8, boot_addr_i=0xFE -> PCs 0xFE then 0x00 delivered.
REQ-030 rst_i asserted while a request is outstanding -> next cycle imem_req_o=0 and instr_valid_o=0; restart from boot_addr_i.

Source files
------------

// File: rtl/simple_processor_pkg.sv
`default_nettype none
// ============================================================================
// Module   : simple_processor_pkg
// Purpose  : Shared widths, PC step and fetch FSM state type for the core.
// Revision : 1.0 - initial release
// ============================================================================
package simple_processor_pkg;

   localparam int ADDR_WIDTH  = 16;
   localparam int DATA_WIDTH  = 16;
   localparam int INSTR_BYTES = 2;

   typedef enum logic [1:0] {
      BOOT    = 2'd0,
      FETCH   = 2'd1,
      DISCARD = 2'd2
   } fetch_state_e;

endpackage
`default_nettype wire

// File: rtl/sync_fifo.sv
`default_nettype none
// ============================================================================
// Module   : sync_fifo
// Purpose  : Single-clock FIFO with flush, power-of-two depth, show-ahead read.
// Revision : 1.0 - initial release
// ============================================================================
module sync_fifo #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 4
) (
   input  logic                     clk_i,
   input  logic                     rst_i,
   input  logic                     push,
   input  logic                     pop,
   input  logic                     flush,
   input  logic [WIDTH-1:0]         wdata,
   output logic [WIDTH-1:0]         rdata,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int            PW     = $clog2(DEPTH);
   localparam logic [PW:0]   C_FULL = (PW+1)'(DEPTH);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [PW-1:0]    r_wr_ptr;
   logic [PW-1:0]    r_rd_ptr;
   logic [PW:0]      r_count;
   logic             w_push;
   logic             w_pop;

   assign empty = (r_count == '0);
   assign full  = (r_count == C_FULL);
   assign count = r_count;
   assign rdata = r_mem[r_rd_ptr];
   assign w_pop  = pop && !empty;
   assign w_push = push && !full;

   // Storage is left unreset; only pointers and count carry state.
   always_ff @(posedge clk_i) begin
      if (w_push && !rst_i && !flush) begin
         r_mem[r_wr_ptr] <= wdata;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i || flush) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

endmodule
`default_nettype wire

// File: rtl/prefetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : prefetch_unit
// Purpose  : Instruction prefetcher: single-outstanding fetch FSM feeding a FIFO.
// Revision : 1.0 - initial release
// ============================================================================
module prefetch_unit #(
   parameter int ADDR_WIDTH  = simple_processor_pkg::ADDR_WIDTH,
   parameter int DATA_WIDTH  = simple_processor_pkg::DATA_WIDTH,
   parameter int DEPTH       = 4,
   parameter int INSTR_BYTES = simple_processor_pkg::INSTR_BYTES
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic [ADDR_WIDTH-1:0] boot_addr_i,
   input  logic                  redirect_i,
   input  logic [ADDR_WIDTH-1:0] redirect_addr_i,
   output logic                  imem_req_o,
   output logic [ADDR_WIDTH-1:0] imem_addr_o,
   input  logic [DATA_WIDTH-1:0] imem_rdata_i,
   input  logic                  imem_ack_i,
   output logic                  instr_valid_o,
   output logic [DATA_WIDTH-1:0] instr_o,
   output logic [ADDR_WIDTH-1:0] instr_pc_o,
   input  logic                  instr_ready_i
);

   import simple_processor_pkg::*;

   localparam int CW = $clog2(DEPTH) + 1;
   localparam int EW = DATA_WIDTH + ADDR_WIDTH;

   fetch_state_e          r_state;
   logic [ADDR_WIDTH-1:0] r_fetch_pc;
   logic [ADDR_WIDTH-1:0] r_req_addr;
   logic                  r_busy;

   logic                  w_req;
   logic                  w_ack;
   logic                  w_push;
   logic                  w_pop;
   logic                  w_full;
   logic                  w_empty;
   logic [CW-1:0]         w_count;
   logic [EW-1:0]         w_head;

   // A request already on the bus is held even if the buffer fills meanwhile.
   always_comb begin
      w_req = 1'b0;
      case (r_state)
         FETCH:   w_req = r_busy || !w_full;
         DISCARD: w_req = 1'b1;
         default: w_req = 1'b0;
      endcase
   end

   assign w_ack         = w_req && imem_ack_i;
   assign w_push        = (r_state == FETCH) && w_ack && !redirect_i;
   assign w_pop         = instr_ready_i && !w_empty;
   assign imem_req_o    = w_req;
   assign imem_addr_o   = r_busy ? r_req_addr : r_fetch_pc;
   assign instr_valid_o = (w_count != '0);
   assign instr_o       = w_head[EW-1 -: DATA_WIDTH];
   assign instr_pc_o    = w_head[ADDR_WIDTH-1:0];

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_state    <= BOOT;
         r_fetch_pc <= '0;
         r_req_addr <= '0;
         r_busy     <= 1'b0;
      end else begin
         case (r_state)
            BOOT: begin
               r_fetch_pc <= redirect_i ? redirect_addr_i : boot_addr_i;
               r_state    <= FETCH;
            end
            FETCH: begin
               if (w_req && !imem_ack_i) begin
                  r_busy     <= 1'b1;
                  r_req_addr <= imem_addr_o;
               end else begin
                  r_busy     <= 1'b0;
               end
               if (redirect_i) begin
                  r_fetch_pc <= redirect_addr_i;
                  if (w_req && !imem_ack_i) r_state <= DISCARD;
               end else if (w_ack) begin
                  r_fetch_pc <= r_fetch_pc + ADDR_WIDTH'(INSTR_BYTES);
               end
            end
            DISCARD: begin
               if (redirect_i) r_fetch_pc <= redirect_addr_i;
               if (imem_ack_i) begin
                  r_busy  <= 1'b0;
                  r_state <= FETCH;
               end
            end
            default: r_state <= BOOT;
         endcase
      end
   end

   sync_fifo #(
      .WIDTH (EW),
      .DEPTH (DEPTH)
   ) u_buf (
      .clk_i (clk_i),
      .rst_i (rst_i),
      .push  (w_push),
      .pop   (w_pop),
      .flush (redirect_i),
      .wdata ({imem_rdata_i, r_fetch_pc}),
      .rdata (w_head),
      .full  (w_full),
      .empty (w_empty),
      .count (w_count)
   );

endmodule
`default_nettype wire

// File: tb/tb_prefetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_prefetch_unit
// Purpose  : Directed and randomized self-checking bench for prefetch_unit.
// Revision : 1.0 - initial release
// ============================================================================
module tb_prefetch_unit;

   localparam int AW    = 16;
   localparam int DW    = 16;
   localparam int DEPTH = 4;
   localparam int IB    = 2;

   logic          clk_i = 1'b0;
   logic          rst_i = 1'b1;
   logic [AW-1:0] boot_addr_i = '0;
   logic          redirect_i = 1'b0;
   logic [AW-1:0] redirect_addr_i = '0;
   logic          imem_req_o;
   logic [AW-1:0] imem_addr_o;
   logic [DW-1:0] imem_rdata_i = '0;
   logic          imem_ack_i = 1'b0;
   logic          instr_valid_o;
   logic [DW-1:0] instr_o;
   logic [AW-1:0] instr_pc_o;
   logic          instr_ready_i = 1'b0;

   always #5 clk_i = ~clk_i;

   prefetch_unit #(
      .ADDR_WIDTH  (AW),
      .DATA_WIDTH  (DW),
      .DEPTH       (DEPTH),
      .INSTR_BYTES (IB)
   ) dut (
      .clk_i           (clk_i),
      .rst_i           (rst_i),
      .boot_addr_i     (boot_addr_i),
      .redirect_i      (redirect_i),
      .redirect_addr_i (redirect_addr_i),
      .imem_req_o      (imem_req_o),
      .imem_addr_o     (imem_addr_o),
      .imem_rdata_i    (imem_rdata_i),
      .imem_ack_i      (imem_ack_i),
      .instr_valid_o   (instr_valid_o),
      .instr_o         (instr_o),
      .instr_pc_o      (instr_pc_o),
      .instr_ready_i   (instr_ready_i)
   );

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: observed 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   function automatic logic [DW-1:0] mem_word(input logic [AW-1:0] a);
      return (a ^ {a[7:0], a[15:8]}) + 16'h3C1D;
   endfunction

   // Stimulus controls
   bit            c_rst = 1'b1, c_ready = 1'b0, c_redirect = 1'b0, c_spur = 1'b0;
   logic [AW-1:0] c_raddr = '0;
   int            c_lat = 0;

   // Reference model: instruction queue plus next/outstanding fetch address
   bit            m_boot = 1'b1, m_busy = 1'b0, m_discard = 1'b0, m_was_rst = 1'b0;
   logic [AW-1:0] m_pc = '0, m_req_addr = '0;
   logic [AW-1:0] m_q[$];

   bit            mem_active = 1'b0;
   int            mem_cnt = 0;
   int            cyc = 0;
   int            first_valid_cyc = -1;
   logic [AW-1:0] acc_addr[$];
   int            acc_cyc[$];
   logic [AW-1:0] delivered[$];

   task automatic cycle();
      bit            exp_req, acc, pop;
      logic [AW-1:0] cur_addr;
      @(negedge clk_i);
      cyc++;
      exp_req  = !m_boot && (m_discard || m_busy || m_q.size() < DEPTH);
      cur_addr = m_busy ? m_req_addr : m_pc;
      check_eq("req", imem_req_o, exp_req);
      check_eq("valid", instr_valid_o, m_q.size() != 0);
      if (exp_req)   check_eq("addr", imem_addr_o, cur_addr);
      if (m_was_rst) check_eq("rst_addr", imem_addr_o, 0);
      if (m_q.size() != 0) begin
         check_eq("head_pc", instr_pc_o, m_q[0]);
         check_eq("head_instr", instr_o, mem_word(m_q[0]));
      end
      if (instr_valid_o && first_valid_cyc < 0) first_valid_cyc = cyc;

      rst_i           = c_rst;
      instr_ready_i   = c_ready;
      redirect_i      = c_redirect;
      redirect_addr_i = c_raddr;
      if (imem_req_o) begin
         if (!mem_active) begin
            mem_active = 1'b1;
            mem_cnt    = (c_lat < 0) ? int'($urandom_range(0, 3)) : c_lat;
         end
         imem_ack_i   = (mem_cnt == 0);
         imem_rdata_i = imem_ack_i ? mem_word(imem_addr_o) : DW'($urandom);
         if (imem_ack_i) mem_active = 1'b0;
         else            mem_cnt--;
      end else begin
         mem_active   = 1'b0;
         imem_ack_i   = c_spur && ($urandom_range(0, 1) == 1);
         imem_rdata_i = DW'($urandom);
      end
      if (c_rst) mem_active = 1'b0;
      if (instr_valid_o && instr_ready_i) delivered.push_back(instr_pc_o);

      acc = exp_req && imem_ack_i;
      pop = (m_q.size() != 0) && c_ready;
      if (acc && !c_rst) begin
         acc_addr.push_back(cur_addr);
         acc_cyc.push_back(cyc);
      end
      m_was_rst = c_rst;
      if (c_rst) begin
         m_boot = 1'b1; m_busy = 1'b0; m_discard = 1'b0; m_pc = '0;
         m_q.delete();
      end else if (m_boot) begin
         m_boot = 1'b0;
         m_pc   = c_redirect ? c_raddr : boot_addr_i;
      end else if (c_redirect) begin
         m_q.delete();
         if (m_discard) begin
            if (acc) begin m_discard = 1'b0; m_busy = 1'b0; end
         end else if (exp_req && !imem_ack_i) begin
            m_discard = 1'b1; m_busy = 1'b1; m_req_addr = cur_addr;
         end else begin
            m_busy = 1'b0;
         end
         m_pc = c_raddr;
      end else if (m_discard) begin
         if (acc) begin m_discard = 1'b0; m_busy = 1'b0; end
      end else begin
         if (pop) void'(m_q.pop_front());
         if (acc) begin
            m_q.push_back(m_pc);
            m_pc   = m_pc + AW'(IB);
            m_busy = 1'b0;
         end else if (exp_req) begin
            m_busy = 1'b1; m_req_addr = m_pc;
         end
      end
   endtask

   int rel_cyc;

   initial begin
      // Boot sequence, zero-wait memory, consumer always ready
      boot_addr_i = 16'h0100;
      c_rst = 1'b1; c_ready = 1'b1; c_lat = 0;
      repeat (3) cycle();
      check_eq("reset_req", imem_req_o, 0);
      check_eq("reset_valid", instr_valid_o, 0);
      check_eq("reset_addr", imem_addr_o, 0);
      acc_addr.delete(); acc_cyc.delete(); first_valid_cyc = -1;
      c_rst = 1'b0; cycle(); rel_cyc = cyc;
      repeat (6) cycle();
      check_eq("boot_ack_count", acc_addr.size() >= 3, 1);
      if (acc_addr.size() >= 3) begin
         check_eq("boot_addr0", acc_addr[0], 16'h0100);
         check_eq("boot_addr1", acc_addr[1], 16'h0102);
         check_eq("boot_addr2", acc_addr[2], 16'h0104);
         check_eq("boot_back2back", acc_cyc[2] - acc_cyc[0], 2);
      end
      check_eq("first_valid_latency", first_valid_cyc - rel_cyc, 2);

      // Fill with consumer stalled, then release one entry
      c_rst = 1'b1; c_ready = 1'b0; repeat (2) cycle();
      c_rst = 1'b0; acc_addr.delete();
      repeat (10) cycle();
      check_eq("full_ack_count", acc_addr.size(), 4);
      check_eq("full_req_low", imem_req_o, 0);
      check_eq("full_head", instr_pc_o, 16'h0100);
      c_ready = 1'b1; cycle();
      c_ready = 1'b0; cycle();
      check_eq("refill_req", imem_req_o, 1);
      check_eq("refill_addr", imem_addr_o, 16'h0108);
      repeat (3) cycle();
      check_eq("refill_ack_count", acc_addr.size(), 5);
      check_eq("head_after_pop", instr_pc_o, 16'h0102);

      // Redirect while a slow request is outstanding
      c_lat = 3; c_ready = 1'b1; cycle();
      c_ready = 1'b0; cycle();
      check_eq("slow_req_rise", imem_req_o, 1);
      acc_addr.delete();
      c_redirect = 1'b1; c_raddr = 16'h0400; cycle();
      c_redirect = 1'b0; cycle();
      check_eq("discard_hold_addr", imem_addr_o, 16'h010A);
      check_eq("discard_no_valid", instr_valid_o, 0);
      c_ready = 1'b1; repeat (10) cycle();
      check_eq("discard_ack_count", acc_addr.size() >= 2, 1);
      if (acc_addr.size() >= 2) begin
         check_eq("dropped_addr", acc_addr[0], 16'h010A);
         check_eq("post_redirect_addr", acc_addr[1], 16'h0400);
      end

      // Redirect coincident with an ack into a nearly full buffer
      c_lat = 0; c_ready = 1'b0;
      for (int i = 0; i < 20 && m_q.size() < 3; i++) cycle();
      c_redirect = 1'b1; c_raddr = 16'h0400; cycle();
      c_redirect = 1'b0; cycle();
      check_eq("redir_ack_empty", instr_valid_o, 0);
      check_eq("redir_ack_req", imem_req_o, 1);
      check_eq("redir_ack_addr", imem_addr_o, 16'h0400);

      // PC wrap at the top of the address space
      boot_addr_i = 16'hFFFE; c_rst = 1'b1; c_ready = 1'b1;
      repeat (2) cycle();
      c_rst = 1'b0; delivered.delete();
      repeat (6) cycle();
      check_eq("wrap_count", delivered.size() >= 2, 1);
      if (delivered.size() >= 2) begin
         check_eq("wrap_pc0", delivered[0], 16'hFFFE);
         check_eq("wrap_pc1", delivered[1], 16'h0000);
      end

      // Reset while a request is outstanding
      c_lat = 3;
      for (int i = 0; i < 20 && !(imem_req_o && mem_active); i++) cycle();
      boot_addr_i = 16'h0300; c_rst = 1'b1; cycle();
      c_rst = 1'b0; cycle();
      check_eq("mid_req_rst_req", imem_req_o, 0);
      check_eq("mid_req_rst_valid", instr_valid_o, 0);
      c_lat = 0; delivered.delete();
      repeat (6) cycle();
      check_eq("restart_count", delivered.size() >= 1, 1);
      if (delivered.size() >= 1) check_eq("restart_pc", delivered[0], 16'h0300);

      // Randomized traffic against the model
      c_lat = -1; c_spur = 1'b1;
      for (int i = 0; i < 3000; i++) begin
         c_rst      = ($urandom_range(0, 199) == 0);
         c_ready    = ($urandom_range(0, 3) != 0);
         c_redirect = ($urandom_range(0, 15) == 0);
         c_raddr    = AW'($urandom) & ~AW'(1);
         if (c_rst) boot_addr_i = AW'($urandom) & ~AW'(1);
         cycle();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
